// File: rtl/seq_rec.sv
// Run-length recorder: samples IN each CLK and packs (value, dwell) slots into PTN
// in the pattern sequencer's layout. Optional feature macro: SEQ_REC_TRIG_EN (arm waits for IN to change).

module seq_rec_slot #(
   parameter int            W    = 6,
   parameter logic [W-1:0]  INIT = '0
)(
   input  logic         CLK,
   input  logic         RSTX,
   input  logic         clr,
   input  logic         we,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);
   always_ff @(posedge CLK or negedge RSTX) begin
      if (!RSTX)    q <= INIT;
      else if (clr) q <= INIT;
      else if (we)  q <= d;
   end
endmodule

module seq_rec #(
   parameter int                BW_SEQ     = 4,
   parameter int                SEQ_CNT    = 7,
   parameter int                BW_SEQ_CNT = 3,
   parameter int                BW_TIMEOUT = 2,
   parameter logic [BW_SEQ-1:0] RV         = '0
)(
   input  logic                                         CLK,
   input  logic                                         RSTX,
   input  logic                                         CLR,
   input  logic                                         STOP,
   input  logic [BW_SEQ-1:0]                            IN,
   output logic [(BW_SEQ+BW_TIMEOUT)*(SEQ_CNT+1)-1:0]   PTN,
   output logic [BW_SEQ_CNT:0]                          NSLOT,
   output logic                                         BUSY,
   output logic                                         DONE
);
   localparam int                      SW       = BW_SEQ + BW_TIMEOUT;
   localparam int                      NS       = SEQ_CNT + 1;
   localparam logic [BW_TIMEOUT-1:0]   DW_MAX   = {BW_TIMEOUT{1'b1}};
   localparam logic [BW_SEQ_CNT-1:0]   IDX_TOP  = BW_SEQ_CNT'(SEQ_CNT);
   localparam logic [BW_SEQ_CNT:0]     NS_MAX   = (BW_SEQ_CNT+1)'(NS);
   localparam logic [SW-1:0]           SLOT_RST = {RV, {BW_TIMEOUT{1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_ARM, S_REC, S_DONE} state_t;

   typedef struct packed {
      logic [BW_SEQ-1:0]     val;
      logic [BW_TIMEOUT-1:0] dwell;
   } slot_t;

   state_t                   state;
   logic [BW_SEQ-1:0]        cur;
   logic [BW_TIMEOUT-1:0]    dwell;
   logic [BW_SEQ_CNT-1:0]    idx;
`ifdef SEQ_REC_TRIG_EN
   logic [BW_SEQ-1:0]        trig_ref;
`endif
   logic                     close;
   slot_t                    wr_slot;
   logic [SEQ_CNT:0]         slot_we;
   logic [SEQ_CNT:0][SW-1:0] slot_q;

   // A slot closes on STOP, a value change, or a saturated dwell; CLR wins over all.
   always_comb begin
      close = 1'b0;
      if (state == S_REC && !CLR)
         close = STOP || (IN != cur) || (dwell == DW_MAX);
   end

   assign wr_slot = '{val: cur, dwell: dwell};

   always_comb begin
      slot_we = '0;
      if (close) slot_we[idx] = 1'b1;
   end

   for (genvar k = 0; k < NS; k++) begin : g_slot
      seq_rec_slot #(.W(SW), .INIT(SLOT_RST)) u_slot (
         .CLK  (CLK),
         .RSTX (RSTX),
         .clr  (CLR),
         .we   (slot_we[k]),
         .d    (wr_slot),
         .q    (slot_q[k])
      );
   end

   assign PTN = slot_q;

   always_ff @(posedge CLK or negedge RSTX) begin
      if (!RSTX) begin
         state    <= S_IDLE;
         cur      <= '0;
         dwell    <= '0;
         idx      <= IDX_TOP;
         NSLOT    <= '0;
         BUSY     <= 1'b0;
         DONE     <= 1'b0;
`ifdef SEQ_REC_TRIG_EN
         trig_ref <= '0;
`endif
      end else if (CLR) begin
         state    <= S_ARM;
         dwell    <= '0;
         idx      <= IDX_TOP;
         NSLOT    <= '0;
         BUSY     <= 1'b1;
         DONE     <= 1'b0;
`ifdef SEQ_REC_TRIG_EN
         trig_ref <= IN;
`endif
      end else begin
         case (state)
            S_ARM: begin
`ifdef SEQ_REC_TRIG_EN
               if (STOP) begin
                  state <= S_DONE;
                  BUSY  <= 1'b0;
                  DONE  <= 1'b1;
               end else if (IN != trig_ref) begin
                  cur   <= IN;
                  dwell <= '0;
                  state <= S_REC;
               end
`else
               cur   <= IN;
               dwell <= '0;
               state <= S_REC;
`endif
            end
            S_REC: begin
               if (close) begin
                  NSLOT <= (NSLOT == NS_MAX) ? NSLOT : NSLOT + 1'b1;
                  // Last slot or STOP: the sample on IN is not recorded.
                  if (STOP || idx == '0) begin
                     state <= S_DONE;
                     BUSY  <= 1'b0;
                     DONE  <= 1'b1;
                  end else begin
                     idx   <= idx - 1'b1;
                     cur   <= IN;
                     dwell <= '0;
                  end
               end else begin
                  dwell <= dwell + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_seq_rec.sv
// Randomized scoreboard bench for seq_rec: the model turns the sample stream into
// runs, splits runs into dwell-limited slots, and a monitor checks each capture at DONE.

module tb_seq_rec;
   localparam int BW_SEQ = 4, SEQ_CNT = 7, BW_SEQ_CNT = 3, BW_TIMEOUT = 2;
   localparam int SW = BW_SEQ + BW_TIMEOUT, NS = SEQ_CNT + 1, PW = SW * NS;
   localparam int RUNMAX = 1 << BW_TIMEOUT;
   localparam logic [BW_SEQ-1:0] RV = '0;
   localparam logic [PW-1:0] PTN_CLR = {NS{{RV, {BW_TIMEOUT{1'b0}}}}};

   logic              CLK = 1'b0, RSTX = 1'b0, CLR = 1'b0, STOP = 1'b0;
   logic [BW_SEQ-1:0] IN = '0;
   logic [PW-1:0]     PTN;
   logic [BW_SEQ_CNT:0] NSLOT;
   logic              BUSY, DONE;

   typedef struct {
      logic [PW-1:0] ptn;
      int            nslot;
   } exp_t;

   exp_t              sb[$];
   logic [BW_SEQ-1:0] smp[$];
   int vectors = 0, miscompares = 0;

   seq_rec #(
      .BW_SEQ(BW_SEQ), .SEQ_CNT(SEQ_CNT), .BW_SEQ_CNT(BW_SEQ_CNT),
      .BW_TIMEOUT(BW_TIMEOUT), .RV(RV)
   ) dut (
      .CLK(CLK), .RSTX(RSTX), .CLR(CLR), .STOP(STOP), .IN(IN),
      .PTN(PTN), .NSLOT(NSLOT), .BUSY(BUSY), .DONE(DONE)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Samples recorded start at the cycle after CLR; with the trigger option the
   // leading samples equal to the CLR-cycle value are skipped.
   function automatic exp_t model(input logic [BW_SEQ-1:0] v0);
      exp_t              e;
      logic [BW_SEQ-1:0] vals[$];
      int                lens[$];
      int                start = 0;
      e.ptn   = PTN_CLR;
      e.nslot = 0;
`ifdef SEQ_REC_TRIG_EN
      while (start < smp.size() && smp[start] == v0) start++;
`else
      if (v0 == v0) start = 0;
`endif
      for (int i = start; i < smp.size(); i++) begin
         if (vals.size() > 0 && smp[i] == vals[vals.size()-1])
            lens[lens.size()-1] += 1;
         else begin
            vals.push_back(smp[i]);
            lens.push_back(1);
         end
      end
      foreach (vals[r]) begin
         int l = lens[r];
         while (l > 0 && e.nslot < NS) begin
            int c = (l > RUNMAX) ? RUNMAX : l;
            e.ptn[SW*(SEQ_CNT-e.nslot) +: SW] = {vals[r], BW_TIMEOUT'(c-1)};
            e.nslot++;
            l -= c;
         end
      end
      return e;
   endfunction

   task automatic cyc(input logic c, input logic s, input logic [BW_SEQ-1:0] v);
      CLR = c; STOP = s; IN = v;
      @(posedge CLK); #1;
   endtask

   task automatic run_txn(input logic [BW_SEQ-1:0] v0, input logic stop_with_clr);
      exp_t e;
      e = model(v0);
      sb.push_back(e);
      cyc(1'b1, stop_with_clr, v0);
      chk("clr_ptn",   64'(PTN),   64'(PTN_CLR));
      chk("clr_nslot", 64'(NSLOT), 64'd0);
      chk("clr_busy",  64'(BUSY),  64'd1);
      chk("clr_done",  64'(DONE),  64'd0);
      foreach (smp[i]) cyc(1'b0, 1'b0, smp[i]);
      cyc(1'b0, 1'b1, BW_SEQ'($urandom));
      for (int j = 0; j < 5; j++) cyc(1'b0, 1'($urandom), BW_SEQ'($urandom));
      chk("hold_ptn",   64'(PTN),   64'(e.ptn));
      chk("hold_nslot", 64'(NSLOT), 64'(e.nslot));
      chk("hold_done",  64'(DONE),  64'd1);
      STOP = 1'b0;
   endtask

   // Monitor: one scoreboard entry per rising DONE.
   initial begin
      logic pd;
      exp_t e;
      pd = 1'b0;
      forever begin
         @(negedge CLK);
         if (DONE && !pd) begin
            if (sb.size() == 0) begin
               vectors++; miscompares++;
               $display("FAIL unexpected_done: got DONE=1 expected no capture pending");
            end else begin
               e = sb.pop_front();
               chk("done_ptn",   64'(PTN),   64'(e.ptn));
               chk("done_nslot", 64'(NSLOT), 64'(e.nslot));
               chk("done_busy",  64'(BUSY),  64'd0);
            end
         end
         pd = DONE;
      end
   end

   initial begin
      #12;
      chk("rst_ptn",   64'(PTN),   64'(PTN_CLR));
      chk("rst_nslot", 64'(NSLOT), 64'd0);
      chk("rst_busy",  64'(BUSY),  64'd0);
      chk("rst_done",  64'(DONE),  64'd0);
      RSTX = 1'b1;
      @(posedge CLK); #1;

      // Value changes every cycle: slots fill completely, later samples dropped.
      smp.delete();
      for (int i = 0; i < 10; i++) smp.push_back(BW_SEQ'(i));
      run_txn(4'hF, 1'b0);

      smp = '{4'h3, 4'h3, 4'h5, 4'h9};
      run_txn(4'h0, 1'b0);

      smp.delete();
      for (int i = 0; i < 10; i++) smp.push_back(4'hA);
      run_txn(4'h0, 1'b0);

      // Abort mid-recording with CLR and STOP together.
      cyc(1'b1, 1'b0, 4'h0);
      for (int i = 1; i <= 4; i++) cyc(1'b0, 1'b0, BW_SEQ'(i));
      chk("mid_nslot", 64'(NSLOT), 64'd3);
      chk("mid_busy",  64'(BUSY),  64'd1);
      smp = '{4'h7, 4'h7, 4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'hC};
      run_txn(4'h1, 1'b1);

      // Asynchronous reset between clock edges.
      cyc(1'b1, 1'b0, 4'h0);
      for (int i = 1; i <= 4; i++) cyc(1'b0, 1'b0, BW_SEQ'(i));
      #2 RSTX = 1'b0;
      #1;
      chk("arst_ptn",   64'(PTN),   64'(PTN_CLR));
      chk("arst_nslot", 64'(NSLOT), 64'd0);
      chk("arst_busy",  64'(BUSY),  64'd0);
      chk("arst_done",  64'(DONE),  64'd0);
      RSTX = 1'b1;
      @(posedge CLK); #1;

      for (int t = 0; t < 30; t++) begin
         int n;
         n = $urandom_range(1, 30);
         smp.delete();
         while (smp.size() < n) begin
            logic [BW_SEQ-1:0] v;
            int                len;
            v   = BW_SEQ'($urandom);
            len = $urandom_range(1, 7);
            for (int k = 0; k < len && smp.size() < n; k++) smp.push_back(v);
         end
         run_txn(BW_SEQ'($urandom), 1'($urandom));
      end

      repeat (3) @(posedge CLK);
      #1;
      chk("sb_empty", 64'(sb.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
